// File: rtl/gray_counter.sv
`default_nettype none
// ============================================================================
// Module      : gray_counter
// Description : Up/down Gray-code counter with a loadable binary value and a
//               valid/ready output slot toward a Gray-to-binary stage.
// Revision    : 1.0 - initial release
// ============================================================================
module gray_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             ld_ack,
    output logic [WIDTH-1:0] g,
    output logic             g_valid,
    input  logic             g_ready,
    output logic             tc
);

    localparam logic [WIDTH-1:0] c_one = WIDTH'(1);

    logic [WIDTH-1:0] r_bin;
    logic [WIDTH-1:0] r_g;
    logic             r_valid;
    logic             r_tc;
    logic             r_ld_ack;

    logic             w_free;
    logic [WIDTH-1:0] w_next;
    logic             w_wrap;

    function automatic logic [WIDTH-1:0] f_gray(input logic [WIDTH-1:0] b);
        return b ^ (b >> 1);
    endfunction

    assign w_free = !r_valid || g_ready;
    assign w_next = up ? (r_bin + c_one) : (r_bin - c_one);
    // A wrap is leaving all-ones upward or zero downward.
    assign w_wrap = up ? (&r_bin) : ~(|r_bin);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_bin    <= '0;
            r_g      <= '0;
            r_valid  <= 1'b0;
            r_tc     <= 1'b0;
            r_ld_ack <= 1'b0;
        end else begin
            r_ld_ack <= 1'b0;
            if (w_free) begin
                if (load) begin
                    r_bin    <= load_val;
                    r_g      <= f_gray(load_val);
                    r_valid  <= 1'b1;
                    r_tc     <= 1'b0;
                    r_ld_ack <= 1'b1;
                end else if (en) begin
                    r_bin   <= w_next;
                    r_g     <= f_gray(w_next);
                    r_valid <= 1'b1;
                    r_tc    <= w_wrap;
                end else begin
                    // Slot drained (or already empty); the code itself holds.
                    r_valid <= 1'b0;
                    r_tc    <= 1'b0;
                end
            end
        end
    end

    assign g       = r_g;
    assign g_valid = r_valid;
    assign tc      = r_tc;
    assign ld_ack  = r_ld_ack;

endmodule
`default_nettype wire

// File: tb/tb_gray_counter.sv
`default_nettype none
// ============================================================================
// Module      : tb_gray_counter
// Description : Directed and randomised-ready checks of gray_counter (WIDTH=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gray_counter;

    localparam int WIDTH = 4;

    logic             clk;
    logic             rst_n;
    logic             en;
    logic             up;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             ld_ack;
    logic [WIDTH-1:0] g;
    logic             g_valid;
    logic             g_ready;
    logic             tc;

    int total;
    int bad;

    gray_counter #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .up       (up),
        .load     (load),
        .load_val (load_val),
        .ld_ack   (ld_ack),
        .g        (g),
        .g_valid  (g_valid),
        .g_ready  (g_ready),
        .tc       (tc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Checks all four state outputs at once against hand-computed values.
    task automatic check_out(input string tag, input logic [3:0] eg, input logic ev,
                             input logic et, input logic ea);
        check({tag, ".g"}, 32'(g), 32'(eg));
        check({tag, ".valid"}, 32'(g_valid), 32'(ev));
        check({tag, ".tc"}, 32'(tc), 32'(et));
        check({tag, ".ld_ack"}, 32'(ld_ack), 32'(ea));
    endtask

    function automatic logic [3:0] gray2bin(input logic [3:0] gc);
        logic [3:0] b;
        b[3] = gc[3];
        for (int k = 2; k >= 0; k--) b[k] = b[k+1] ^ gc[k];
        return b;
    endfunction

    initial begin
        logic [3:0] m_bin;
        logic       m_valid;
        logic [3:0] prev_g;
        logic       have_prev;
        logic       free;
        logic       wrap;
        int         nup;
        int         ndn;
        int         iter;

        total    = 0;
        bad      = 0;
        rst_n    = 1'b0;
        en       = 1'b0;
        up       = 1'b1;
        load     = 1'b0;
        load_val = '0;
        g_ready  = 1'b1;
        tick();
        tick();
        check_out("reset", 4'b0000, 1'b0, 1'b0, 1'b0);

        // Count up from reset.
        rst_n = 1'b1;
        en    = 1'b1;
        up    = 1'b1;
        tick(); check_out("up1", 4'b0001, 1'b1, 1'b0, 1'b0);
        tick(); check_out("up2", 4'b0011, 1'b1, 1'b0, 1'b0);
        tick(); check_out("up3", 4'b0010, 1'b1, 1'b0, 1'b0);
        tick(); check_out("up4", 4'b0110, 1'b1, 1'b0, 1'b0);

        // Load 14, then step across the wrap.
        en       = 1'b0;
        load     = 1'b1;
        load_val = 4'd14;
        tick(); check_out("load14", 4'b1001, 1'b1, 1'b0, 1'b1);
        load = 1'b0;
        en   = 1'b1;
        tick(); check_out("step15", 4'b1000, 1'b1, 1'b0, 1'b0);
        tick(); check_out("wrap0", 4'b0000, 1'b1, 1'b1, 1'b0);
        en = 1'b0;
        tick(); check_out("drain", 4'b0000, 1'b0, 1'b0, 1'b0);

        // Count down from reset wraps immediately.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        en    = 1'b1;
        up    = 1'b0;
        tick(); check_out("dn15", 4'b1000, 1'b1, 1'b1, 1'b0);
        tick(); check_out("dn14", 4'b1001, 1'b1, 1'b0, 1'b0);

        // Stall with en and load pending.
        rst_n = 1'b0;
        en    = 1'b0;
        tick();
        rst_n = 1'b1;
        en    = 1'b1;
        up    = 1'b1;
        tick();
        tick(); check_out("pre_stall", 4'b0011, 1'b1, 1'b0, 1'b0);
        g_ready  = 1'b0;
        load     = 1'b1;
        load_val = 4'd5;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_out("stall", 4'b0011, 1'b1, 1'b0, 1'b0);
        end
        g_ready = 1'b1;
        tick(); check_out("stall_load", 4'b0111, 1'b1, 1'b0, 1'b1);
        load = 1'b0;
        tick(); check_out("after_load", 4'b0101, 1'b1, 1'b0, 1'b0);

        // Reset during a stalled transfer.
        en      = 1'b0;
        g_ready = 1'b0;
        tick(); check_out("hold", 4'b0101, 1'b1, 1'b0, 1'b0);
        rst_n = 1'b0;
        tick(); check_out("rst_stall", 4'b0000, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;

        // Free-running up then down with random downstream ready.
        m_bin     = '0;
        m_valid   = 1'b0;
        have_prev = 1'b0;
        prev_g    = '0;
        nup       = 0;
        ndn       = 0;
        iter      = 0;
        en        = 1'b1;
        while ((nup < 40 || ndn < 40) && iter < 2000) begin
            up      = (nup < 40);
            g_ready = 1'($urandom_range(0, 1));
            free    = !m_valid || g_ready;
            wrap    = up ? (m_bin == 4'hF) : (m_bin == 4'h0);
            tick();
            iter++;
            if (free) begin
                m_bin   = up ? m_bin + 4'd1 : m_bin - 4'd1;
                m_valid = 1'b1;
                if (up) nup++; else ndn++;
                check("rand.g", 32'(g), 32'(m_bin ^ (m_bin >> 1)));
                check("rand.bin", 32'(gray2bin(g)), 32'(m_bin));
                check("rand.tc", 32'(tc), 32'(wrap));
                if (have_prev)
                    check("rand.onebit", 32'($countones(g ^ prev_g)), 32'd1);
                prev_g    = g;
                have_prev = 1'b1;
            end else begin
                check("rand.stall_g", 32'(g), 32'(prev_g));
            end
            check("rand.valid", 32'(g_valid), 32'(m_valid));
        end
        check("rand.budget", 32'(nup + ndn), 32'd80);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/gray_counter.md
GRAY_COUNTER -- requirements
Module: gray_counter

Interface
REQ-001 Parameter: WIDTH, default 4, code width in bits; legal range 2..16.
REQ-002 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  reset, synchronous, active-low.
REQ-004 Port: en  input  1  count enable; requests one count step per accepted transfer.
REQ-005 Port: up  input  1  direction; 1 = increment, 0 = decrement; sampled with en.
REQ-006 Port: load  input  1  load request; source holds high until ld_ack.
REQ-007 Port: load_val  input  WIDTH  binary load value; sampled when the load is accepted.
REQ-008 Port: ld_ack  output  1  one-cycle pulse in the cycle after a load is accepted.
REQ-009 Port: g  output  WIDTH  registered Gray code presented to the downstream Gray-to-binary stage.
REQ-010 Port: g_valid  output  1  g holds a code not yet accepted downstream.
REQ-011 Port: g_ready  input  1  downstream accepts g in any cycle where g_valid && g_ready.
REQ-012 Port: tc  output  1  terminal-count flag, qualified by g_valid; marks a wrapped code.

Function
REQ-013 Internal binary register bin[WIDTH-1:0]; g SHALL always equal bin ^ (bin >> 1) for the value last stepped or loaded.
REQ-014 Slot free: free = !g_valid || g_ready.
REQ-015 Priority per cycle: load over en; both require free.
REQ-016 Load accept (load && free): bin <= load_val; g <= gray(load_val); g_valid <= 1; tc <= 0; ld_ack <= 1 next cycle.
REQ-017 Step (en && !load && free): bin <= up ? bin+1 : bin-1, modulo 2^WIDTH; g <= gray(new bin); g_valid <= 1.
REQ-018 tc <= 1 on a step from all-ones with up=1, or from zero with up=0; otherwise tc <= 0 on any step or load.
REQ-019 Drain: g_valid && g_ready && !en && !load -> g_valid <= 0, tc <= 0; bin and g hold.
REQ-020 Stall: g_valid && !g_ready -> g, tc, bin and g_valid SHALL NOT change; load and en are ignored (no ld_ack).
REQ-021 Latency: a step or load accepted in cycle N presents its code with g_valid=1 in cycle N+1.
REQ-022 Throughput: one code per cycle with en=1 and g_ready=1 held.
REQ-023 Consecutive stepped codes SHALL differ in exactly one bit, including across the wrap; a loaded code carries no such guarantee.
REQ-024 Direction change between steps is legal: the next code is the neighbour of the current bin in the new direction.
REQ-025 ld_ack SHALL be low in every cycle except the one after an accepted load.
REQ-026 All outputs are registered; no combinational path from any input to any output.

Reset
REQ-027 rst_n=0 at a rising edge: bin=0, g=0, g_valid=0, tc=0, ld_ack=0, overriding load, en and any stall.
REQ-028 Reset mid-transfer discards the held code; downstream sees g_valid=0 the cycle after.
REQ-029 The first step after reset with up=1 presents g=0001 (WIDTH=4); code 0000 is not presented until a wrap or load.

Verification (WIDTH=4)
REQ-030 Reset, then en=1, up=1, g_ready=1 for 4 cycles -> g = 0001, 0011, 0010, 0110 on consecutive cycles, g_valid=1, tc=0.
REQ-031 Load 1110 (bin 14), then step up twice -> g = 1001, then 1000, then 0000 with tc=1 on 0000 only; ld_ack pulses once.
REQ-032 Reset, en=1, up=0 -> first code g=1000 (bin 15) with tc=1; next step g=1001, tc=0.
REQ-033 g=0011 valid, g_ready=0 for 5 cycles with en=1 and load=1 -> g stays 0011, no ld_ack; g_ready=1 -> load accepted, next g = gray(load_val).
REQ-034 Free-running 40 up and 40 down steps with random g_ready -> every accepted pair of stepped codes differs in one bit; scoreboard bin = converted g.
REQ-035 rst_n=0 for one edge while g_valid=1 and g_ready=0 -> next cycle g=0000, g_valid=0, tc=0, ld_ack=0.
